fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- IF stage and IF/ID boundary of the 5-stage MIPS32 pipeline.
- Consumes the decode-stage branch decision (pc_src_d) and jump request. Owns the fetch PC, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID register.
- Flushes the wrong-path fetch on every taken branch or jump. There is no delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- CNT_W, 16, width of the redirect statistics counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- stall_d  in  1  hazard unit: hold IF/ID contents
- pc_src_d  in  1  taken-branch decision from the branch comparison logic
- pc_branch_d  in  32  branch target computed in ID
- jump_d  in  1  decoded J/JAL/JR in ID
- jump_target_d  in  32  jump target computed in ID
- imem_req  out  1  instruction fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  response valid this cycle, qualifies imem_rdata
- imem_rdata  in  32  fetched instruction
- instr_d  out  32  IF/ID instruction
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  request outstanding and not yet answered (to hazard unit)
- redirect_count  out  CNT_W  number of redirects taken since reset

Behaviour:
- Redirect conditions:
  - redirect = valid_d & ~stall_d & (jump_d | pc_src_d).
  - Target = jump_target_d if jump_d, else pc_branch_d; jump has priority.
  - pc_src_d and jump_d are ignored when valid_d=0 or stall_d=1.
- Reset: while rst_n=0 on a clk edge:
  - pc_f=RESET_PC, state=FETCH, instr_d=0, pc_plus4_d=0, valid_d=0, redirect_count=0.
  - imem_req=0 while rst_n is low.
- "Bubble" means instr_d<=0 (NOP), pc_plus4_d unchanged, valid_d<=0.
- IF/ID changes only when stall_d=0, except when reset is asserted.
- State FETCH: imem_req=1, imem_addr=pc_f.
  - imem_ready & redirect: drop response; bubble; pc_f<=target; stay FETCH.
  - imem_ready & ~stall_d: instr_d<=imem_rdata, pc_plus4_d<=pc_f+4, valid_d<=1; pc_f<=pc_f+4.
  - imem_ready & stall_d: buf_instr<=imem_rdata, buf_pc4<=pc_f+4; pc_f<=pc_f+4; go to HELD.
  - ~imem_ready & redirect: tgt<=target; bubble; go to DISCARD. pc_f and imem_addr stay stable until the response arrives.
  - ~imem_ready & ~stall_d: bubble.
- State HELD: imem_req=0.
  - redirect: discard buf; bubble; pc_f<=target; go to FETCH.
  - ~stall_d: instr_d<=buf_instr, pc_plus4_d<=buf_pc4, valid_d<=1; go to FETCH.
  - stall_d: hold.
- State DISCARD: imem_req=1, imem_addr=pc_f (old address).
  - imem_ready: drop response; pc_f<=tgt; go to FETCH.
  - Bubble whenever ~stall_d.
  - A redirect cannot occur here because valid_d=0.
- fetch_busy = imem_req & ~imem_ready.
- redirect_count increments by 1 on every redirect cycle and wraps modulo 2^CNT_W.
- pc_f+4 wraps modulo 2^32.
- imem_addr[1:0] is always 0. Targets are used as given (ID guarantees alignment).
- Latency: a response accepted in cycle N appears in IF/ID in cycle N+1 when not stalled. On a redirect in cycle N, the request for the target is issued in cycle N+1, or the cycle after the old response arrives if the old request is still pending.

Decomposition:
- Shared package pipeline_pkg holds:
  - fetch state enum {FETCH, HELD, DISCARD}
  - NOP_INSTR = 32'h0000_0000
  - the INSTR_W and ADDR_W widths.
- One natural sub-module: fetch_target_select. It is combinational and produces redirect and target from valid_d, stall_d, jump_d, pc_src_d and the two targets. It is reused by the hazard unit for flush decisions.
- Everything else stays in this module.

Test Plan:
1. Reset with RESET_PC=0x0000_0040, imem_ready=1 constantly, rdata = address -> addresses 0x40, 0x44, 0x48 issued on consecutive cycles; instr_d=0x40 with pc_plus4_d=0x44 and valid_d=1 one cycle after the first accept; redirect_count=0.
2. Taken branch: pc_src_d=1 with pc_branch_d=0x100 while valid_d=1 -> next imem_addr=0x100; the instruction fetched in the redirect cycle never appears; valid_d=0 for one cycle; redirect_count=1.
3. stall_d=1 for 3 cycles while a response arrives -> state HELD, imem_req=0; instr_d unchanged; after release the buffered word loads into IF/ID; no word is lost or duplicated.
4. Redirect while imem_ready=0 (jump_d=1, target 0x200, memory answers 4 cycles later) -> imem_addr holds the old address; the old response is dropped; the next request is 0x200; fetch_busy=1 throughout the wait.
5. jump_d=1 and pc_src_d=1 together (targets 0x300 / 0x400) -> fetch goes to 0x300; pc_src_d with valid_d=0 -> ignored.
6. rst_n=0 asserted in DISCARD and in HELD -> all outputs return to reset values next edge; 2^16 redirects -> redirect_count wraps to 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, NOP encoding and the fetch-stage state type.
package pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // FETCH: request outstanding at pc_f
    // HELD: word captured during a stall, waiting to enter IF/ID
    // DISCARD: wrong-path request still in flight, its response is dropped
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HELD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_target_select.sv
// Decides whether ID redirects fetch this cycle and which target wins.
// Also used by the hazard unit, so it stays purely combinational.
module fetch_target_select
    import pipeline_pkg::*;
(
    input  logic              valid_d,
    input  logic              stall_d,
    input  logic              jump_d,
    input  logic              pc_src_d,
    input  logic [ADDR_W-1:0] pc_branch_d,
    input  logic [ADDR_W-1:0] jump_target_d,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    // A stalled or empty ID slot cannot redirect; jumps override branches.
    always_comb begin
        redirect = valid_d & ~stall_d & (jump_d | pc_src_d);
        target   = jump_d ? jump_target_d : pc_branch_d;
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF stage plus IF/ID register: fetch PC, imem handshake, one-entry hold
// buffer for words that arrive during a stall, and wrong-path flushing.
module fetch_redirect_unit
    import pipeline_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_d,
    input  logic               pc_src_d,
    input  logic [ADDR_W-1:0]  pc_branch_d,
    input  logic               jump_d,
    input  logic [ADDR_W-1:0]  jump_target_d,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_d,
    output logic [ADDR_W-1:0]  pc_plus4_d,
    output logic               valid_d,
    output logic               fetch_busy,
    output logic [CNT_W-1:0]   redirect_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]  buf_pc4_q, buf_pc4_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc4_q, ifid_pc4_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_plus4_f;

    assign pc_plus4_f = pc_q + 32'd4;

    fetch_target_select u_sel (
        .valid_d       (ifid_valid_q),
        .stall_d       (stall_d),
        .jump_d        (jump_d),
        .pc_src_d      (pc_src_d),
        .pc_branch_d   (pc_branch_d),
        .jump_target_d (jump_target_d),
        .redirect      (redirect),
        .target        (target)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next state: capture during stall, or park until a wrong-path response drains.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (!redirect && stall_d) state_d = HELD;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            HELD:    if (redirect || !stall_d) state_d = FETCH;
            DISCARD: if (imem_ready) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Outputs: request whenever not holding a captured word; address is always pc_f.
    always_comb begin
        imem_req   = rst_n && (state_q != HELD);
        imem_addr  = pc_q;
        fetch_busy = imem_req & ~imem_ready;
    end

    // Datapath next values: fetch PC, hold buffer, pending target and IF/ID.
    always_comb begin
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, redirect};
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        // Response belongs to the wrong path: drop it and flush ID.
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                        pc_d         = target;
                    end else if (!stall_d) begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_plus4_f;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4_f;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4_f;
                        pc_d        = pc_plus4_f;
                    end
                end else if (redirect) begin
                    // Keep pc_f on the old address so the outstanding request stays stable.
                    tgt_d        = target;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (!stall_d) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
            end
            HELD: begin
                if (redirect) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    pc_d         = target;
                end else if (!stall_d) begin
                    ifid_instr_d = buf_instr_q;
                    ifid_pc4_d   = buf_pc4_q;
                    ifid_valid_d = 1'b1;
                end
            end
            DISCARD: begin
                if (imem_ready) pc_d = tgt_q;
                if (!stall_d) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            buf_instr_q  <= '0;
            buf_pc4_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign instr_d        = ifid_instr_q;
    assign pc_plus4_d     = ifid_pc4_q;
    assign valid_d        = ifid_valid_q;
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed scenarios plus a randomized run against a behavioural fetch model.
// The counter is narrowed to 8 bits so the wrap can be reached in a short run.
module tb_fetch_redirect_unit;

    localparam logic [31:0] RPC = 32'h0000_0040;
    localparam int          CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_d = 1'b0, pc_src_d = 1'b0, jump_d = 1'b0, imem_ready = 1'b0;
    logic [31:0]   pc_branch_d = '0, jump_target_d = '0, mem_key = '0;
    logic          imem_req, valid_d, fetch_busy;
    logic [31:0]   imem_addr, imem_rdata, instr_d, pc_plus4_d;
    logic [CW-1:0] redirect_count;

    int            n_chk = 0, n_err = 0;
    logic [CW-1:0] exp_cnt = '0;

    // Memory answers with a word derived from the requested address.
    assign imem_rdata = imem_addr ^ mem_key;

    fetch_redirect_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .pc_src_d(pc_src_d),
        .pc_branch_d(pc_branch_d), .jump_d(jump_d), .jump_target_d(jump_target_d),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .fetch_busy(fetch_busy), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; imem_ready = 1; mem_key = '0;
        cyc(); cyc();
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== 65'd0) begin n_err++; $display("FAIL reset_ifid: got %h %h %b want zeros", instr_d, pc_plus4_d, valid_d); end
        n_chk++; if (redirect_count !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", redirect_count); end
        rst_n = 1; #1;
        n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL first_req: got %b %h want 1 00000040", imem_req, imem_addr); end
        cyc();
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== {32'h40, 32'h44, 1'b1}) begin n_err++; $display("FAIL first_ifid: got %h %h %b want 40 44 1", instr_d, pc_plus4_d, valid_d); end
        n_chk++; if (imem_addr !== 32'h44) begin n_err++; $display("FAIL second_addr: got %h want 44", imem_addr); end
        cyc();
        n_chk++; if ({imem_addr, instr_d} !== {32'h48, 32'h44}) begin n_err++; $display("FAIL third_addr: got %h %h want 48 44", imem_addr, instr_d); end
    endtask

    task automatic test_branch();
        pc_src_d = 1; pc_branch_d = 32'h100;
        cyc();
        pc_src_d = 0; exp_cnt++;
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== {32'h0, 32'h48, 1'b0}) begin n_err++; $display("FAIL branch_bubble: got %h %h %b want 0 48 0", instr_d, pc_plus4_d, valid_d); end
        n_chk++; if ({imem_addr, redirect_count} !== {32'h100, exp_cnt}) begin n_err++; $display("FAIL branch_addr_cnt: got %h %0d want 100 %0d", imem_addr, redirect_count, exp_cnt); end
        cyc();
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== {32'h100, 32'h104, 1'b1}) begin n_err++; $display("FAIL branch_target: got %h %h %b want 100 104 1", instr_d, pc_plus4_d, valid_d); end
    endtask

    task automatic test_stall();
        stall_d = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++; if ({imem_req, instr_d, valid_d} !== {1'b0, 32'h100, 1'b1}) begin n_err++; $display("FAIL stall_hold%0d: got %b %h %b want 0 100 1", i, imem_req, instr_d, valid_d); end
        end
        stall_d = 0;
        cyc();
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== {32'h104, 32'h108, 1'b1}) begin n_err++; $display("FAIL stall_release: got %h %h %b want 104 108 1", instr_d, pc_plus4_d, valid_d); end
        n_chk++; if ({imem_req, imem_addr} !== {1'b1, 32'h108}) begin n_err++; $display("FAIL stall_resume: got %b %h want 1 108", imem_req, imem_addr); end
        cyc();
        n_chk++; if ({instr_d, pc_plus4_d} !== {32'h108, 32'h10C}) begin n_err++; $display("FAIL stall_next: got %h %h want 108 10c", instr_d, pc_plus4_d); end
    endtask

    task automatic test_discard();
        imem_ready = 0; jump_d = 1; jump_target_d = 32'h200; #1;
        n_chk++; if (fetch_busy !== 1'b1) begin n_err++; $display("FAIL discard_busy0: got %b want 1", fetch_busy); end
        cyc();
        jump_d = 0; exp_cnt++;
        n_chk++; if ({imem_req, imem_addr, fetch_busy, valid_d} !== {1'b1, 32'h10C, 1'b1, 1'b0}) begin n_err++; $display("FAIL discard_enter: got %b %h %b %b want 1 10c 1 0", imem_req, imem_addr, fetch_busy, valid_d); end
        n_chk++; if (redirect_count !== exp_cnt) begin n_err++; $display("FAIL discard_cnt: got %0d want %0d", redirect_count, exp_cnt); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_chk++; if ({imem_addr, fetch_busy, valid_d} !== {32'h10C, 1'b1, 1'b0}) begin n_err++; $display("FAIL discard_wait%0d: got %h %b %b want 10c 1 0", i, imem_addr, fetch_busy, valid_d); end
        end
        imem_ready = 1;
        cyc();
        n_chk++; if ({imem_req, imem_addr, valid_d} !== {1'b1, 32'h200, 1'b0}) begin n_err++; $display("FAIL discard_drop: got %b %h %b want 1 200 0", imem_req, imem_addr, valid_d); end
        cyc();
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== {32'h200, 32'h204, 1'b1}) begin n_err++; $display("FAIL discard_target: got %h %h %b want 200 204 1", instr_d, pc_plus4_d, valid_d); end
    endtask

    task automatic test_priority();
        jump_d = 1; pc_src_d = 1; jump_target_d = 32'h300; pc_branch_d = 32'h400;
        cyc();
        jump_d = 0; exp_cnt++;
        n_chk++; if ({imem_addr, valid_d, redirect_count} !== {32'h300, 1'b0, exp_cnt}) begin n_err++; $display("FAIL prio_jump: got %h %b %0d want 300 0 %0d", imem_addr, valid_d, redirect_count, exp_cnt); end
        // pc_src_d still high while the ID slot is empty: must be ignored.
        cyc();
        pc_src_d = 0;
        n_chk++; if ({instr_d, valid_d, imem_addr, redirect_count} !== {32'h300, 1'b1, 32'h304, exp_cnt}) begin n_err++; $display("FAIL prio_ignore: got %h %b %h %0d want 300 1 304 %0d", instr_d, valid_d, imem_addr, redirect_count, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        imem_ready = 0; jump_d = 1; jump_target_d = 32'h500;
        cyc();
        jump_d = 0;
        rst_n = 0; #1;
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_discard_req: got %b want 0", imem_req); end
        cyc();
        exp_cnt = '0;
        n_chk++; if ({instr_d, pc_plus4_d, valid_d, redirect_count} !== {65'd0, {CW{1'b0}}}) begin n_err++; $display("FAIL rst_discard_ifid: got %h %h %b %0d want zeros", instr_d, pc_plus4_d, valid_d, redirect_count); end
        rst_n = 1; imem_ready = 1; #1;
        n_chk++; if ({imem_req, imem_addr} !== {1'b1, RPC}) begin n_err++; $display("FAIL rst_discard_pc: got %b %h want 1 %h", imem_req, imem_addr, RPC); end
        cyc();
        stall_d = 1;
        cyc();
        n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL held_req: got %b want 0", imem_req); end
        rst_n = 0;
        cyc();
        rst_n = 1; stall_d = 0; #1;
        n_chk++; if ({imem_req, imem_addr, instr_d, valid_d} !== {1'b1, RPC, 32'h0, 1'b0}) begin n_err++; $display("FAIL rst_held: got %b %h %h %b want 1 %h 0 0", imem_req, imem_addr, instr_d, valid_d, RPC); end
        cyc();
        n_chk++; if ({instr_d, pc_plus4_d, valid_d} !== {32'h40, 32'h44, 1'b1}) begin n_err++; $display("FAIL rst_held_refetch: got %h %h %b want 40 44 1", instr_d, pc_plus4_d, valid_d); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < (1 << CW); i++) begin
            pc_src_d = 1; pc_branch_d = 32'h1000;
            cyc();
            pc_src_d = 0; exp_cnt++;
            cyc();
            if (i == (1 << CW) - 2) begin
                n_chk++; if (redirect_count !== exp_cnt) begin n_err++; $display("FAIL wrap_pre: got %0d want %0d", redirect_count, exp_cnt); end
            end
        end
        n_chk++; if (redirect_count !== {CW{1'b0}}) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", redirect_count); end
    endtask

    // Reference model: fetch address, IF/ID, a captured word and a to-be-dropped request.
    task automatic test_random();
        logic [31:0] m_pc, m_instr, m_pc4, m_bi, m_bp, m_tgt, tgt, rdata;
        logic        m_valid, m_held, m_drop, red, exp_req;
        logic [CW-1:0] m_cnt;
        rst_n = 0; stall_d = 0; jump_d = 0; pc_src_d = 0;
        cyc();
        rst_n = 1; mem_key = 32'hC0DE_0000;
        m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_held = 0; m_drop = 0;
        m_bi = 0; m_bp = 0; m_tgt = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            imem_ready    = ($urandom_range(0, 9) < 7);
            stall_d       = ($urandom_range(0, 3) == 0);
            jump_d        = ($urandom_range(0, 6) == 0);
            pc_src_d      = ($urandom_range(0, 3) == 0);
            jump_target_d = $urandom() & 32'hFFFF_FFFC;
            pc_branch_d   = $urandom() & 32'hFFFF_FFFC;
            #1;
            exp_req = !m_held;
            n_chk++; if ({imem_req, fetch_busy} !== {exp_req, exp_req & ~imem_ready}) begin n_err++; $display("FAIL rnd_req c%0d: got %b %b want %b %b", c, imem_req, fetch_busy, exp_req, exp_req & ~imem_ready); end
            if (exp_req) begin
                n_chk++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, m_pc); end
            end
            red   = m_valid && !stall_d && (jump_d || pc_src_d);
            tgt   = jump_d ? jump_target_d : pc_branch_d;
            rdata = m_pc ^ mem_key;
            if (red) m_cnt++;
            if (m_held) begin
                if (red) begin m_instr = 0; m_valid = 0; m_pc = tgt; m_held = 0; end
                else if (!stall_d) begin m_instr = m_bi; m_pc4 = m_bp; m_valid = 1; m_held = 0; end
            end else if (m_drop) begin
                if (imem_ready) begin m_pc = m_tgt; m_drop = 0; end
                if (!stall_d) begin m_instr = 0; m_valid = 0; end
            end else if (imem_ready) begin
                if (red) begin m_instr = 0; m_valid = 0; m_pc = tgt; end
                else if (!stall_d) begin m_instr = rdata; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; end
                else begin m_bi = rdata; m_bp = m_pc + 4; m_pc = m_pc + 4; m_held = 1; end
            end else if (red) begin
                m_tgt = tgt; m_instr = 0; m_valid = 0; m_drop = 1;
            end else if (!stall_d) begin
                m_instr = 0; m_valid = 0;
            end
            cyc();
            n_chk++; if ({instr_d, pc_plus4_d, valid_d, redirect_count} !== {m_instr, m_pc4, m_valid, m_cnt}) begin n_err++; $display("FAIL rnd_ifid c%0d: got %h %h %b %0d want %h %h %b %0d", c, instr_d, pc_plus4_d, valid_d, redirect_count, m_instr, m_pc4, m_valid, m_cnt); end
        end
        stall_d = 0; jump_d = 0; pc_src_d = 0;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_discard();
        test_priority();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
